// File: rtl/rle_dec_if.sv
// AXI4-stream bundle shared by the run-length decoder input and output sides.
// Source-side modports (s/master) drive the payload; sink-side modports (d/slave) drive TREADY.
interface axi4_stream_if #(
    parameter int DW = 8,
    parameter int DN = 1
) (
    input logic ACLK,
    input logic ARESETn
);
    logic          TVALID;
    logic          TREADY;
    logic          TLAST;
    logic [DW-1:0] TDATA;
    logic [DN-1:0] TKEEP;

    modport s (
        input  ACLK, ARESETn, TREADY,
        output TVALID, TDATA, TLAST, TKEEP
    );

    modport d (
        input  ACLK, ARESETn, TVALID, TDATA, TLAST, TKEEP,
        output TREADY
    );

    modport master (
        input  ACLK, ARESETn, TREADY,
        output TVALID, TDATA, TLAST, TKEEP
    );

    modport slave (
        input  ACLK, ARESETn, TVALID, TDATA, TLAST, TKEEP,
        output TREADY
    );
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: each {cnt, dat} input word is replayed cnt+1 times on the output stream.
// A single holding register carries the word; the input is re-opened on the last repetition.
//
//   state    | meaning
//   ST_IDLE  | nothing held, input always ready
//   ST_HOLD  | word held and presented on sto; hld_cnt_q = extra repeats still owed
module rle_dec #(
    parameter int CW = 8,
    parameter int DW = 8,
    parameter int SW = 32
) (
    axi4_stream_if.d    sti,
    axi4_stream_if.s    sto,
    input  logic          ctl_rst,
    input  logic          cfg_ena,
    output logic          sts_run,
    output logic [SW-1:0] sts_smp
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   hld_dat_q, hld_dat_d;
    logic [CW-1:0]   hld_cnt_q, hld_cnt_d;
    logic            hld_lst_q, hld_lst_d;
    logic [SW-1:0]   smp_q, smp_d;

    logic            last_rep;
    logic            in_rdy;
    logic            ld;
    logic            em;
    logic [CW-1:0]   in_cnt;
    logic [DW-1:0]   in_dat;

    assign in_cnt   = sti.TDATA[CW+DW-1:DW];
    assign in_dat   = sti.TDATA[DW-1:0];
    assign last_rep = (hld_cnt_q == '0);
    // Ready is combinational from sto.TREADY so the next word lands in the same cycle the last repeat leaves.
    assign in_rdy   = (state_q == ST_IDLE) | (sto.TREADY & last_rep);
    assign ld       = sti.TVALID & in_rdy;
    assign em       = (state_q == ST_HOLD) & sto.TREADY;

    always_ff @(posedge sti.ACLK) begin
        if (!sti.ARESETn || ctl_rst) begin
            state_q   <= ST_IDLE;
            hld_dat_q <= '0;
            hld_cnt_q <= '0;
            hld_lst_q <= 1'b0;
            smp_q     <= '0;
        end else begin
            state_q   <= state_d;
            hld_dat_q <= hld_dat_d;
            hld_cnt_q <= hld_cnt_d;
            hld_lst_q <= hld_lst_d;
            smp_q     <= smp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hld_dat_d = hld_dat_q;
        hld_cnt_d = hld_cnt_q;
        hld_lst_d = hld_lst_q;
        smp_d     = smp_q + {{(SW-1){1'b0}}, em};

        if (em) begin
            if (!last_rep) begin
                hld_cnt_d = hld_cnt_q - 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // A load in the same cycle as the final repeat overrides the drop to idle.
        if (ld) begin
            state_d   = ST_HOLD;
            hld_dat_d = in_dat;
            hld_lst_d = sti.TLAST;
            hld_cnt_d = cfg_ena ? in_cnt : '0;
        end
    end

    always_comb begin
        sti.TREADY = in_rdy;
        sto.TVALID = (state_q == ST_HOLD);
        sto.TDATA  = hld_dat_q;
        sto.TLAST  = hld_lst_q & last_rep;
        sto.TKEEP  = '1;
        sts_run    = (state_q == ST_HOLD);
        sts_smp    = smp_q;
    end

endmodule

// File: tb/tb_rle_dec.sv
// Directed bench for rle_dec: reset, repeat expansion, back-to-back runs, backpressure,
// bypass mode, maximum count and soft clear, each with hand-computed expected beats.
module tb_rle_dec;
    localparam int CW = 8;
    localparam int DW = 8;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.DW(CW+DW), .DN(1)) sti_if (.ACLK(clk), .ARESETn(rst_n));
    axi4_stream_if #(.DW(DW),    .DN(1)) sto_if (.ACLK(clk), .ARESETn(rst_n));

    logic          ctl_rst;
    logic          cfg_ena;
    logic          sts_run;
    logic [SW-1:0] sts_smp;

    int total_cnt = 0;
    int pass_cnt  = 0;

    rle_dec #(.CW(CW), .DW(DW), .SW(SW)) dut (
        .sti     (sti_if),
        .sto     (sto_if),
        .ctl_rst (ctl_rst),
        .cfg_ena (cfg_ena),
        .sts_run (sts_run),
        .sts_smp (sts_smp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (sto_if.TVALID !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", sto_if.TVALID);
        else pass_cnt++;
        total_cnt++;
        if (sts_run !== 1'b0) $display("FAIL reset_run got=%b exp=0", sts_run);
        else pass_cnt++;
        total_cnt++;
        if (sts_smp !== 32'd0) $display("FAIL reset_smp got=%0d exp=0", sts_smp);
        else pass_cnt++;
        total_cnt++;
        if (sti_if.TREADY !== 1'b1) $display("FAIL reset_tready got=%b exp=1", sti_if.TREADY);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_repeat();
        cfg_ena = 1'b1;
        sto_if.TREADY = 1'b1;
        sti_if.TDATA  = {8'd3, 8'hA5};
        sti_if.TLAST  = 1'b1;
        sti_if.TVALID = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (sti_if.TREADY !== 1'b1) $display("FAIL rep_accept got=%b exp=1", sti_if.TREADY);
        else pass_cnt++;
        tick();
        sti_if.TVALID = 1'b0;
        sti_if.TLAST  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== 8'hA5)
                $display("FAIL rep_beat%0d got v=%b d=%h exp v=1 d=a5", i, sto_if.TVALID, sto_if.TDATA);
            else pass_cnt++;
            total_cnt++;
            if (sto_if.TLAST !== (i == 3)) $display("FAIL rep_last%0d got=%b exp=%b", i, sto_if.TLAST, (i == 3));
            else pass_cnt++;
            tick();
        end
        @(negedge clk);
        total_cnt++;
        if (sto_if.TVALID !== 1'b0) $display("FAIL rep_done got=%b exp=0", sto_if.TVALID);
        else pass_cnt++;
        total_cnt++;
        if (sts_smp !== 32'd4) $display("FAIL rep_smp got=%0d exp=4", sts_smp);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [7:0]  exp_out [5];
        logic        exp_rdy [5];
        int          idx;
        logic        hs;
        words   = '{16'h0011, 16'h0222, 16'h0033};
        exp_out = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33};
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        idx = 0;
        sto_if.TREADY = 1'b1;
        sti_if.TLAST  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sti_if.TVALID = (idx < 3);
            sti_if.TDATA  = (idx < 3) ? words[idx] : 16'h0;
            @(negedge clk);
            if (i >= 1) begin
                total_cnt++;
                if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== exp_out[i-1])
                    $display("FAIL b2b_out%0d got v=%b d=%h exp v=1 d=%h", i, sto_if.TVALID, sto_if.TDATA, exp_out[i-1]);
                else pass_cnt++;
            end
            if (i <= 4) begin
                total_cnt++;
                if (sti_if.TREADY !== exp_rdy[i])
                    $display("FAIL b2b_rdy%0d got=%b exp=%b", i, sti_if.TREADY, exp_rdy[i]);
                else pass_cnt++;
            end
            hs = sti_if.TVALID & sti_if.TREADY;
            tick();
            if (hs) idx++;
        end
        sti_if.TVALID = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (idx !== 3) $display("FAIL b2b_accepted got=%0d exp=3", idx);
        else pass_cnt++;
        total_cnt++;
        if (sto_if.TVALID !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", sto_if.TVALID);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        logic rdy_pat [6];
        logic exp_in_rdy [6];
        int   xfers;
        rdy_pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_in_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        xfers = 0;
        sti_if.TDATA  = {8'd2, 8'h5A};
        sti_if.TLAST  = 1'b0;
        sti_if.TVALID = 1'b1;
        sto_if.TREADY = 1'b0;
        tick();
        sti_if.TDATA = {8'd0, 8'h66};
        for (int i = 0; i < 6; i++) begin
            sto_if.TREADY = rdy_pat[i];
            @(negedge clk);
            total_cnt++;
            if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== 8'h5A)
                $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=5a", i, sto_if.TVALID, sto_if.TDATA);
            else pass_cnt++;
            total_cnt++;
            if (sti_if.TREADY !== exp_in_rdy[i])
                $display("FAIL bp_inrdy%0d got=%b exp=%b", i, sti_if.TREADY, exp_in_rdy[i]);
            else pass_cnt++;
            if (sto_if.TVALID && sto_if.TREADY) xfers++;
            tick();
        end
        sti_if.TVALID = 1'b0;
        sto_if.TREADY = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (xfers !== 3) $display("FAIL bp_xfers got=%0d exp=3", xfers);
        else pass_cnt++;
        total_cnt++;
        if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== 8'h66)
            $display("FAIL bp_next got v=%b d=%h exp v=1 d=66", sto_if.TVALID, sto_if.TDATA);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_bypass_and_max();
        int beats;
        ctl_rst = 1'b1;
        tick();
        ctl_rst = 1'b0;
        cfg_ena = 1'b0;
        sto_if.TREADY = 1'b1;
        sti_if.TLAST  = 1'b0;
        sti_if.TVALID = 1'b1;
        sti_if.TDATA  = {8'hFF, 8'h01};
        tick();
        sti_if.TDATA  = {8'h07, 8'h02};
        @(negedge clk);
        total_cnt++;
        if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== 8'h01)
            $display("FAIL byp_beat0 got v=%b d=%h exp v=1 d=01", sto_if.TVALID, sto_if.TDATA);
        else pass_cnt++;
        tick();
        sti_if.TVALID = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== 8'h02)
            $display("FAIL byp_beat1 got v=%b d=%h exp v=1 d=02", sto_if.TVALID, sto_if.TDATA);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (sto_if.TVALID !== 1'b0 || sts_smp !== 32'd2)
            $display("FAIL byp_done got v=%b smp=%0d exp v=0 smp=2", sto_if.TVALID, sts_smp);
        else pass_cnt++;
        tick();

        cfg_ena = 1'b1;
        sti_if.TDATA  = {8'hFF, 8'h03};
        sti_if.TLAST  = 1'b1;
        sti_if.TVALID = 1'b1;
        tick();
        sti_if.TVALID = 1'b0;
        sti_if.TLAST  = 1'b0;
        cfg_ena = 1'b0;
        beats = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!sto_if.TVALID) break;
            if (sto_if.TDATA !== 8'h03 || sto_if.TLAST !== (beats == 255)) begin
                total_cnt++;
                $display("FAIL max_beat%0d got d=%h l=%b exp d=03 l=%b", beats, sto_if.TDATA, sto_if.TLAST, (beats == 255));
            end
            beats++;
            tick();
        end
        total_cnt++;
        if (beats !== 256) $display("FAIL max_count got=%0d exp=256", beats);
        else pass_cnt++;
        total_cnt++;
        if (sts_smp !== 32'd258) $display("FAIL max_smp got=%0d exp=258", sts_smp);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_ctl_rst();
        cfg_ena = 1'b1;
        sto_if.TREADY = 1'b1;
        sti_if.TDATA  = {8'd10, 8'h77};
        sti_if.TLAST  = 1'b1;
        sti_if.TVALID = 1'b1;
        tick();
        sti_if.TVALID = 1'b0;
        sti_if.TLAST  = 1'b0;
        repeat (3) tick();
        ctl_rst = 1'b1;
        tick();
        ctl_rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (sto_if.TVALID !== 1'b0 || sts_run !== 1'b0)
            $display("FAIL clr_valid got v=%b run=%b exp 0 0", sto_if.TVALID, sts_run);
        else pass_cnt++;
        total_cnt++;
        if (sts_smp !== 32'd0) $display("FAIL clr_smp got=%0d exp=0", sts_smp);
        else pass_cnt++;
        tick();
        sti_if.TDATA  = {8'd1, 8'h88};
        sti_if.TLAST  = 1'b1;
        sti_if.TVALID = 1'b1;
        tick();
        sti_if.TVALID = 1'b0;
        sti_if.TLAST  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if (sto_if.TVALID !== 1'b1 || sto_if.TDATA !== 8'h88 || sto_if.TLAST !== (i == 1))
                $display("FAIL clr_beat%0d got v=%b d=%h l=%b exp v=1 d=88 l=%b",
                         i, sto_if.TVALID, sto_if.TDATA, sto_if.TLAST, (i == 1));
            else pass_cnt++;
            tick();
        end
        @(negedge clk);
        total_cnt++;
        if (sto_if.TVALID !== 1'b0 || sts_smp !== 32'd2)
            $display("FAIL clr_done got v=%b smp=%0d exp v=0 smp=2", sto_if.TVALID, sts_smp);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        ctl_rst = 1'b0;
        cfg_ena = 1'b1;
        sti_if.TVALID = 1'b0;
        sti_if.TDATA  = '0;
        sti_if.TLAST  = 1'b0;
        sti_if.TKEEP  = '1;
        sto_if.TREADY = 1'b0;
        test_reset();
        test_repeat();
        test_back_to_back();
        test_backpressure();
        test_bypass_and_max();
        test_ctl_rst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
